// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the pipelined integer register file: default sizes
// and the clear/run state encoding.
package regfile_scoreboard_pkg;

  localparam int RF_XLEN      = 32;
  localparam int RF_REG_DEPTH = 32;
  localparam int RF_NREAD     = 2;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port,
// reservation port and the ready flag.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
) ();

  logic                    ready;
  logic [NREAD*AW-1:0]     rd_addr;
  logic [NREAD*XLEN-1:0]   rd_data;
  logic [NREAD-1:0]        rd_pend;
  logic                    we;
  logic [AW-1:0]           wa;
  logic [XLEN-1:0]         wd;
  logic                    rsv_en;
  logic [AW-1:0]           rsv_addr;

  modport master (
    input  ready, rd_data, rd_pend,
    output rd_addr, we, wa, wd, rsv_en, rsv_addr
  );

  modport slave (
    output ready, rd_data, rd_pend,
    input  rd_addr, we, wa, wd, rsv_en, rsv_addr
  );

endinterface

// File: rtl/regfile_scoreboard_rf_read_port.sv
// One combinational read port: zero-register handling, write-to-read bypass
// and pending-write lookup.
module rf_read_port #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 1
) (
  input  logic            i_run,
  input  logic [AW-1:0]   i_ra,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic            i_pend,
  output logic [XLEN-1:0] o_data,
  output logic            o_pend
);

  logic w_zero;
  logic w_hit;

  assign w_zero = (ZERO_REG0 != 0) && (i_ra == {AW{1'b0}});
  assign w_hit  = (BYPASS != 0) && i_we && (i_wa == i_ra) &&
                  !((ZERO_REG0 != 0) && (i_wa == {AW{1'b0}}));

  // Priority: clearing, hardwired zero, bypassed write data, stored value.
  always_comb begin
    o_data = {XLEN{1'b0}};
    o_pend = 1'b0;
    if (!i_run || w_zero) begin
      o_data = {XLEN{1'b0}};
      o_pend = 1'b0;
    end else if (w_hit) begin
      o_data = i_wd;
      o_pend = 1'b0;
    end else begin
      o_data = i_mem_data;
      o_pend = i_pend;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NREAD read ports, bypass, hardwired x0 and a
// pending-write scoreboard; storage is zeroed one entry per cycle after reset.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN      = RF_XLEN,
  parameter int DEPTH     = RF_REG_DEPTH,
  parameter int NREAD     = RF_NREAD,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [AW-1:0]     r_clr_idx;
  logic [AW-1:0]     w_clr_idx_nxt;
  logic              r_ready;
  logic              w_ready_nxt;
  logic [XLEN-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [DEPTH-1:0]  w_pend_nxt;
  logic              w_run;
  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic [NREAD*XLEN-1:0] w_rd_data;
  logic [NREAD-1:0]      w_rd_pend;

  assign w_run    = (r_state == RF_RUN);
  assign w_wr_ok  = w_run && bus.we &&
                    !((ZERO_REG0 != 0) && (bus.wa == {AW{1'b0}}));
  assign w_rsv_ok = w_run && bus.rsv_en &&
                    !((ZERO_REG0 != 0) && (bus.rsv_addr == {AW{1'b0}}));

  // Clear sequencer next-state: walk every entry once, then run forever.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_ready_nxt   = r_ready;
    case (r_state)
      RF_CLEAR: begin
        if (r_clr_idx == AW'(DEPTH - 1)) begin
          w_state_nxt   = RF_RUN;
          w_clr_idx_nxt = {AW{1'b0}};
          w_ready_nxt   = 1'b1;
        end else begin
          w_clr_idx_nxt = r_clr_idx + AW'(1);
          w_ready_nxt   = 1'b0;
        end
      end
      RF_RUN: begin
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt   = RF_CLEAR;
        w_clr_idx_nxt = {AW{1'b0}};
        w_ready_nxt   = 1'b0;
      end
    endcase
  end

  // Scoreboard next value: a same-cycle reservation overrides the retiring write.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int k = 0; k < DEPTH; k++) begin
      w_pend_nxt[k] = (w_rsv_ok && (bus.rsv_addr == AW'(k))) ? 1'b1 :
                      (w_wr_ok  && (bus.wa == AW'(k)))       ? 1'b0 : r_pend[k];
    end
  end

  // Control state and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= {AW{1'b0}};
      r_ready   <= 1'b0;
      r_pend    <= {DEPTH{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_ready   <= w_ready_nxt;
      r_pend    <= w_pend_nxt;
    end
  end

  // Storage has no reset so it can map onto RAM; the clear walk zeroes it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run) begin
        r_mem[r_clr_idx] <= {XLEN{1'b0}};
      end else if (w_wr_ok) begin
        r_mem[bus.wa] <= bus.wd;
      end
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = bus.rd_addr[gi*AW +: AW];

    rf_read_port #(
      .XLEN      (XLEN),
      .AW        (AW),
      .BYPASS    (BYPASS),
      .ZERO_REG0 (ZERO_REG0)
    ) u_port (
      .i_run      (w_run),
      .i_ra       (w_ra),
      .i_we       (bus.we),
      .i_wa       (bus.wa),
      .i_wd       (bus.wd),
      .i_mem_data (r_mem[w_ra]),
      .i_pend     (r_pend[w_ra]),
      .o_data     (w_rd_data[gi*XLEN +: XLEN]),
      .o_pend     (w_rd_pend[gi])
    );
  end

  assign bus.rd_data = w_rd_data;
  assign bus.rd_pend = w_rd_pend;
  assign bus.ready   = r_ready;

endmodule
